// File: rtl/spring_motor_ctrl_if.sv
// Spring motor controller bus: the dispense request, tray select and sensor
// inputs, plus the motor drive and status outputs, bundled for one port.
interface spring_motor_ctrl_if;
  logic       start;
  logic [2:0] tray_sel;
  logic       drop_sensor;
  logic       clear_fault;
  logic [5:0] motor_en;
  logic       busy;
  logic       done;
  logic       sel_err;
  logic       jam;
  logic [2:0] retry_cnt;

  // Requester side: the vending machine and the sensor front end.
  modport master (
    output start, tray_sel, drop_sensor, clear_fault,
    input  motor_en, busy, done, sel_err, jam, retry_cnt
  );

  // Controller side.
  modport slave (
    input  start, tray_sel, drop_sensor, clear_fault,
    output motor_en, busy, done, sel_err, jam, retry_cnt
  );
endinterface

// File: rtl/spring_motor_ctrl.sv
// Spring motor controller: drives one of six tray motors for a timed
// rotation, waits for the product to drop, retries a limited number of times
// and latches a jam fault that only an operator clear can release.
module spring_motor_ctrl #(
  parameter int unsigned ROT_CYCLES    = 100,
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned MAX_RETRY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spring_motor_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ROTATE = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_JAM    = 3'd4;

  localparam logic [15:0] ROT_LOAD    = 16'(ROT_CYCLES);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);
  localparam logic [2:0]  RETRY_LIMIT = 3'(MAX_RETRY);

  logic [2:0]  state;
  logic [2:0]  tray;
  logic [15:0] timer;
  logic [5:0]  motor;
  logic [2:0]  retry;
  logic        sel_err_q;
  logic        expiring;

  function automatic logic [5:0] tray_onehot(input logic [2:0] t);
    logic [5:0] base;
    base = 6'b000001;
    return base << t;
  endfunction

  // The load value counts the cycle being entered, so a timer reading 1 marks
  // the last cycle of the phase; <= 1 keeps a zero timer from ever wrapping.
  always_comb begin
    expiring = (timer <= 16'd1);
  end

  // Main FSM; motor drive is registered so it is one-hot or zero every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tray      <= '0;
      timer     <= '0;
      motor     <= '0;
      retry     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.tray_sel <= 3'd5) begin
              tray  <= bus.tray_sel;
              retry <= '0;
              timer <= ROT_LOAD;
              motor <= tray_onehot(bus.tray_sel);
              state <= S_ROTATE;
            end else begin
              sel_err_q <= 1'b1;
            end
          end
        end
        S_ROTATE: begin
          if (bus.drop_sensor) begin
            motor <= '0;
            state <= S_DONE;
          end else if (expiring) begin
            motor <= '0;
            timer <= SETTLE_LOAD;
            state <= S_SETTLE;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_SETTLE: begin
          if (bus.drop_sensor) begin
            state <= S_DONE;
          end else if (expiring) begin
            if (retry < RETRY_LIMIT) begin
              retry <= retry + 3'd1;
              timer <= ROT_LOAD;
              motor <= tray_onehot(tray);
              state <= S_ROTATE;
            end else begin
              timer <= '0;
              state <= S_JAM;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_JAM: begin
          if (bus.clear_fault) begin
            state <= S_IDLE;
          end
        end
        default: begin
          motor <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.motor_en  = motor;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.jam       = (state == S_JAM);
  assign bus.sel_err   = sel_err_q;
  assign bus.retry_cnt = retry;

endmodule

// File: tb/tb_spring_motor_ctrl.sv
// Directed bench for spring_motor_ctrl with a scoreboard of expected
// done / sel_err / jam events.
module tb_spring_motor_ctrl;
  localparam int unsigned ROT = 8;
  localparam int unsigned SET = 4;
  localparam int unsigned MR  = 2;

  localparam logic [1:0] EV_DONE = 2'd0;
  localparam logic [1:0] EV_SEL  = 2'd1;
  localparam logic [1:0] EV_JAM  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] retry;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  logic prev_jam = 1'b0;

  always #5 clk = ~clk;

  spring_motor_ctrl_if bus ();

  spring_motor_ctrl #(
    .ROT_CYCLES   (ROT),
    .SETTLE_CYCLES(SET),
    .MAX_RETRY    (MR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] kind, input logic [2:0] retry);
    ev_t e;
    e.kind  = kind;
    e.retry = retry;
    exp_q.push_back(e);
  endtask

  task automatic got(input logic [1:0] kind);
    ev_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_unexpected observed_kind=%0d expected=none", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_kind", 32'(kind), 32'(e.kind));
    chk("sb_retry", 32'(bus.retry_cnt), 32'(e.retry));
  endtask

  // Event monitor: pops the scoreboard whenever the DUT reports an outcome.
  always @(negedge clk) begin
    if (rst) begin
      prev_jam = 1'b0;
    end else begin
      if (bus.done)              got(EV_DONE);
      if (bus.sel_err)           got(EV_SEL);
      if (bus.jam && !prev_jam)  got(EV_JAM);
      prev_jam = bus.jam;
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int on_cnt;
    int off_cnt;
    int rises;
    int bad;
    logic prev_on;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.tray_sel = '0;
    bus.drop_sensor = 1'b0;
    bus.clear_fault = 1'b0;

    // Reset state
    step();
    chk("rst_motor", 32'(bus.motor_en), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_sel_err", 32'(bus.sel_err), 32'h0);
    chk("rst_jam", 32'(bus.jam), 32'h0);
    chk("rst_retry", 32'(bus.retry_cnt), 32'h0);
    step();
    rst = 1'b0;

    // clear_fault and drop_sensor ignored in IDLE
    bus.clear_fault = 1'b1;
    bus.drop_sensor = 1'b1;
    step();
    bus.clear_fault = 1'b0;
    bus.drop_sensor = 1'b0;
    chk("idle_ignore_busy", 32'(bus.busy), 32'h0);
    chk("idle_ignore_done", 32'(bus.done), 32'h0);

    // Tray 1, drop during rotation; tray_sel change after latch has no effect
    bus.tray_sel = 3'd1;
    bus.start = 1'b1;
    push(EV_DONE, 3'd0);
    step();
    bus.start = 1'b0;
    bus.tray_sel = 3'd4;
    chk("t1_motor_first", 32'(bus.motor_en), 32'h02);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    step();
    chk("t1_motor_hold", 32'(bus.motor_en), 32'h02);
    bus.drop_sensor = 1'b1;
    step();
    bus.drop_sensor = 1'b0;
    chk("t1_motor_off", 32'(bus.motor_en), 32'h0);
    chk("t1_done", 32'(bus.done), 32'h1);
    chk("t1_busy_done", 32'(bus.busy), 32'h1);
    step();
    chk("t1_done_pulse", 32'(bus.done), 32'h0);
    chk("t1_busy_low", 32'(bus.busy), 32'h0);
    chk("t1_retry", 32'(bus.retry_cnt), 32'h0);

    // Invalid trays 6 and 7
    bus.tray_sel = 3'd6;
    bus.start = 1'b1;
    push(EV_SEL, 3'd0);
    step();
    bus.start = 1'b0;
    chk("sel6_err", 32'(bus.sel_err), 32'h1);
    chk("sel6_motor", 32'(bus.motor_en), 32'h0);
    chk("sel6_busy", 32'(bus.busy), 32'h0);
    step();
    chk("sel6_pulse", 32'(bus.sel_err), 32'h0);
    chk("sel6_busy2", 32'(bus.busy), 32'h0);
    bus.tray_sel = 3'd7;
    bus.start = 1'b1;
    push(EV_SEL, 3'd0);
    step();
    bus.start = 1'b0;
    chk("sel7_err", 32'(bus.sel_err), 32'h1);
    step();

    // Tray 3, no drop: three rotations, SETTLE gaps, then JAM
    bus.tray_sel = 3'd3;
    bus.start = 1'b1;
    push(EV_JAM, 3'd2);
    step();
    bus.start = 1'b0;
    on_cnt = 0; off_cnt = 0; rises = 0; bad = 0; prev_on = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.jam) break;
      bus.clear_fault = (i < 3);
      if (bus.motor_en != 6'd0) begin
        on_cnt++;
        if (!prev_on) rises++;
        if (bus.motor_en != 6'b001000) bad++;
        prev_on = 1'b1;
      end else begin
        off_cnt++;
        prev_on = 1'b0;
      end
      step();
    end
    bus.clear_fault = 1'b0;
    chk("jam_level", 32'(bus.jam), 32'h1);
    chk("jam_on_cycles", 32'(on_cnt), 32'(3 * ROT));
    chk("jam_off_cycles", 32'(off_cnt), 32'(3 * SET));
    chk("jam_rotations", 32'(rises), 32'h3);
    chk("jam_motor_bits", 32'(bad), 32'h0);
    chk("jam_retry", 32'(bus.retry_cnt), 32'h2);
    chk("jam_busy", 32'(bus.busy), 32'h1);
    chk("jam_motor", 32'(bus.motor_en), 32'h0);
    bus.drop_sensor = 1'b1;
    bus.start = 1'b1;
    bus.tray_sel = 3'd0;
    step();
    bus.drop_sensor = 1'b0;
    bus.start = 1'b0;
    chk("jam_holds", 32'(bus.jam), 32'h1);
    chk("jam_holds_motor", 32'(bus.motor_en), 32'h0);
    bus.clear_fault = 1'b1;
    step();
    bus.clear_fault = 1'b0;
    chk("jam_clear", 32'(bus.jam), 32'h0);
    chk("jam_clear_busy", 32'(bus.busy), 32'h0);

    // Tray 0, drop in SETTLE of the first retry
    bus.tray_sel = 3'd0;
    bus.start = 1'b1;
    push(EV_DONE, 3'd1);
    step();
    bus.start = 1'b0;
    chk("r1_retry_cleared", 32'(bus.retry_cnt), 32'h0);
    chk("r1_motor", 32'(bus.motor_en), 32'h01);
    for (int i = 0; i < 100; i++) begin
      if (bus.retry_cnt == 3'd1 && bus.motor_en == 6'd0) break;
      step();
    end
    chk("r1_reach_settle", 32'(bus.retry_cnt == 3'd1 && bus.motor_en == 6'd0), 32'h1);
    bus.drop_sensor = 1'b1;
    step();
    bus.drop_sensor = 1'b0;
    chk("r1_done", 32'(bus.done), 32'h1);
    chk("r1_retry", 32'(bus.retry_cnt), 32'h1);
    step();
    chk("r1_idle", 32'(bus.busy), 32'h0);
    chk("r1_retry_kept", 32'(bus.retry_cnt), 32'h1);

    // Second start with another tray during ROTATE is ignored
    bus.tray_sel = 3'd2;
    bus.start = 1'b1;
    push(EV_DONE, 3'd0);
    step();
    bus.tray_sel = 3'd5;
    step();
    bus.start = 1'b0;
    chk("ign_motor", 32'(bus.motor_en), 32'h04);
    step();
    chk("ign_motor2", 32'(bus.motor_en), 32'h04);
    bus.drop_sensor = 1'b1;
    step();
    bus.drop_sensor = 1'b0;
    chk("ign_done", 32'(bus.done), 32'h1);
    step();

    // Drop on the last rotate cycle wins over timer expiry
    bus.tray_sel = 3'd5;
    bus.start = 1'b1;
    push(EV_DONE, 3'd0);
    step();
    bus.start = 1'b0;
    for (int i = 1; i < int'(ROT); i++) step();
    chk("prio_last_cycle", 32'(bus.motor_en), 32'h20);
    bus.drop_sensor = 1'b1;
    step();
    bus.drop_sensor = 1'b0;
    chk("prio_done", 32'(bus.done), 32'h1);
    chk("prio_motor", 32'(bus.motor_en), 32'h0);
    step();

    // Reset mid-ROTATE de-energises at once, then a fresh start works
    bus.tray_sel = 3'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("mid_motor", 32'(bus.motor_en), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_motor", 32'(bus.motor_en), 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_retry", 32'(bus.retry_cnt), 32'h0);
    chk("mid_rst_jam", 32'(bus.jam), 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", 32'(bus.busy), 32'h0);
    bus.start = 1'b1;
    push(EV_DONE, 3'd0);
    step();
    bus.start = 1'b0;
    chk("post_rst_motor", 32'(bus.motor_en), 32'h10);
    bus.drop_sensor = 1'b1;
    step();
    bus.drop_sensor = 1'b0;
    chk("post_rst_done", 32'(bus.done), 32'h1);
    step();
    chk("post_rst_busy", 32'(bus.busy), 32'h0);

    step();
    step();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spring_motor_ctrl.md
SPRING_MOTOR_CTRL -- requirements
Module: spring_motor_ctrl

Interface
REQ-001 Parameter ROT_CYCLES, default 100: clock cycles of motor drive per rotation attempt; legal range 1-65535.
REQ-002 Parameter SETTLE_CYCLES, default 20: clock cycles to wait for a drop after the motor stops; legal range 1-65535.
REQ-003 Parameter MAX_RETRY, default 2: extra rotation attempts allowed after the first one fails; legal range 0-7.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  dispense request from vending_machine (its spring_motor_en); sampled each rising edge.
REQ-007 tray_sel  input  3  tray to drive; valid values are 0-5.
REQ-008 drop_sensor  input  1  product-drop detect, already synchronised to clk; active-high.
REQ-009 clear_fault  input  1  operator clear of a jam fault.
REQ-010 motor_en  output  6  one-hot spring motor drive, bit n drives tray n.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when a product drop is confirmed.
REQ-013 sel_err  output  1  one-cycle pulse when start is rejected because tray_sel is 6 or 7.
REQ-014 jam  output  1  level, high while in the JAM state.
REQ-015 retry_cnt  output  3  number of retries used in the current dispense.

Function
REQ-016 The FSM SHALL have the states IDLE, ROTATE, SETTLE, DONE and JAM.
REQ-017 IDLE, start=1, tray_sel<=5: latch tray_sel, clear retry_cnt, load the timer with ROT_CYCLES, go to ROTATE.
REQ-018 IDLE, start=1, tray_sel>=6: pulse sel_err for one cycle and stay in IDLE.
REQ-019 start SHALL be ignored in every state except IDLE; tray_sel changes after the latch SHALL have no effect.
REQ-020 ROTATE: motor_en bit of the latched tray is 1 and all other bits are 0; motor_en becomes non-zero on the cycle after start is accepted.
REQ-021 ROTATE, drop_sensor=1: go to DONE on the next edge; motor_en is 0 from that cycle onward.
REQ-022 ROTATE, drop_sensor=0 and timer expired (exactly ROT_CYCLES cycles with the motor on): load SETTLE_CYCLES, go to SETTLE.
REQ-023 SETTLE: motor_en SHALL be 0; drop_sensor=1 -> DONE.
REQ-024 SETTLE timeout (SETTLE_CYCLES cycles, no drop) with retry_cnt<MAX_RETRY: increment retry_cnt, reload ROT_CYCLES, return to ROTATE on the same tray.
REQ-025 SETTLE timeout with retry_cnt==MAX_RETRY: go to JAM.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE; retry_cnt keeps its value until the next accepted start.
REQ-027 JAM: jam=1, motor_en=0, busy=1; leave to IDLE only on clear_fault=1; clear_fault in any other state is ignored.
REQ-028 If drop_sensor and timer expiry occur in the same cycle, the drop SHALL take priority and the FSM goes to DONE.
REQ-029 drop_sensor SHALL be ignored in IDLE, DONE and JAM.
REQ-030 The timer SHALL be 16 bits and count down; a timer at 0 must never wrap.
REQ-031 motor_en SHALL be driven from a register, never combinationally from any input, and SHALL be one-hot or zero in every cycle.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- motor_en=0, busy=0, done=0, sel_err=0, jam=0;
- retry_cnt=0, timer=0.
REQ-033 Reset asserted during ROTATE SHALL de-energise the motor within the same cycle; after rst falls the block is in IDLE and waits for a new start.

Verification
REQ-034 tray_sel=1, start pulse, drop_sensor=1 on cycle 30 of rotation -> motor_en=6'b000010 from the cycle after start, then 0, done pulse, busy falls, retry_cnt=0.
REQ-035 tray_sel=6, start pulse -> sel_err pulse for 1 cycle, motor_en stays 0, busy stays 0.
REQ-036 tray_sel=3, drop_sensor never asserted, MAX_RETRY=2 -> three rotations of ROT_CYCLES each, separated by SETTLE gaps, then jam=1, retry_cnt=2; clear_fault -> IDLE.
REQ-037 drop_sensor=1 in SETTLE of the first retry -> done pulse, retry_cnt=1.
REQ-038 A second start with a different tray_sel during ROTATE -> ignored, same motor bit stays on.
REQ-039 rst pulse mid-ROTATE -> motor_en=0 at once, all outputs at reset values, next start accepted normally.
